fir_output_decimator: RTL and testbench
=======================================

# fir_output_decimator

Downstream stage of the direct-form FIR filter. Takes the filter's full-precision signed output every valid cycle and drops the first WARMUP samples while the delay line fills. It rescales by an arithmetic right shift with rounding, decimates by DECIM, and buffers results in a small first-word-fall-through FIFO. Results leave on a valid/ready interface toward the DAC/serializer side.

## Interface
- IN_WIDTH, 32: width of the signed filter output sample.
- OUT_WIDTH, 16: width of the signed output sample; must be ≤ IN_WIDTH.
- SHIFT, 15: right-shift applied to undo coefficient scaling (0..IN_WIDTH-1).
- DECIM, 4: decimation ratio (≥1); 1 = keep every sample.
- WARMUP, 8: samples discarded after reset; set to filter order-1; 0 allowed.
- DEPTH, 8: FIFO entries, power of two, ≥2.
- clk  input  1  rising-edge clock, single domain.
- reset  input  1  synchronous, active-high; clears all state on the clock edge.
- in_sample  input  IN_WIDTH  signed filter output.
- in_valid  input  1  in_sample is valid this cycle (no backpressure upstream).
- out_data  output  OUT_WIDTH  signed head of FIFO.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready.
- fifo_level  output  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow  output  1  sticky: a kept sample was dropped because the FIFO was full.
- sat_hit  output  1  sticky: saturation clamped a sample (tied 0 without the macro).

## Operation
- State machine: WARM → RUN. On reset, state = WARM (RUN directly if WARMUP=0) and warm counter = 0.
- WARM: each in_valid increments the counter. The sample is discarded. The in_valid that brings the count to WARMUP is also discarded, and the state moves to RUN on that edge.
- RUN: the decimation counter d (0..DECIM-1) counts in_valid cycles and wraps after DECIM-1. A sample is kept when d==0 at that in_valid; the first RUN sample is kept. Cycles without in_valid change nothing.
- Scaling, computed at IN_WIDTH+1 bits:
  - v = in_sample + 2^(SHIFT-1), with no addend when SHIFT=0.
  - r = v >>> SHIFT (arithmetic shift), giving round-half-up toward +∞.
- Kept samples are registered in a scale stage (s_valid, s_data), then written to the FIFO on the next edge.
- FIFO write is accepted if level < DEPTH, or if a pop occurs in the same cycle.
- If the write is refused, the sample is dropped and overflow is set. FIFO contents are unchanged.
- Pop = out_valid & out_ready. A simultaneous push and pop leaves the level unchanged.
- Read and write pointers are log2(DEPTH) bits and wrap naturally.
- out_data = mem[rd_ptr]. It is don't-care when out_valid=0, but must not be X after the first write.
- reset mid-operation: FIFO empties, counters clear, sticky flags clear, state returns to WARM, and the scale stage is invalidated. A sample in flight is lost.

## Timing
- Reset values:
  - out_valid=0, fifo_level=0, overflow=0, sat_hit=0, out_data=0.
  - Memory contents need no reset.
- Latency: a kept sample with in_valid at edge t is written at edge t+1. out_valid is high after edge t+1 if the FIFO was empty, so it is visible 2 cycles after sampling.
- Throughput: one sample per clock in and out; no upstream stall exists.
- out_valid and fifo_level are registered outputs; out_data comes from memory at the registered read pointer.
- Once out_valid is asserted, out_data must hold stable until popped.

## Configuration
- FIR_OUT_SAT_EN defined:
  - r is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] before the scale register.
  - Any clamp sets sat_hit (sticky until reset).
- FIR_OUT_SAT_EN undefined:
  - out value = r[OUT_WIDTH-1:0] (two's-complement wrap).
  - sat_hit is constant 0.

## Test plan
- Warm-up/decimation: WARMUP=8, DECIM=4, SHIFT=0, in_sample=0,1,2,… with in_valid every cycle, out_ready=1 → outputs 8,12,16,…; nothing before sample 8; first out_valid 2 cycles after sample 8.
- Rounding: SHIFT=2, DECIM=1, WARMUP=0, inputs 5, 6, -6, -5 → outputs 1, 2, -1, -1.
- Saturation (FIR_OUT_SAT_EN): OUT_WIDTH=16, SHIFT=0, inputs 40000 and -40000 → 32767, -32768, sat_hit=1. Without the macro: 40000 → -25536, sat_hit=0.
- Full/overflow: DEPTH=8, DECIM=1, out_ready=0, 10 kept samples → fifo_level=8, overflow=1. Then out_ready=1 drains exactly the first 8 samples in order.
- Simultaneous push/pop at full: level=8, out_ready=1 with a kept sample arriving → level stays 8, overflow stays 0, new sample appears last.
- Mid-stream reset: assert reset for 1 cycle with level=5 → next cycle level=0, out_valid=0, overflow=0; the WARMUP discard restarts.

Source files
------------

// File: rtl/fir_output_decimator.sv
// fir_output_decimator: drops FIR warm-up samples, rounds/rescales, decimates and queues results in a FWFT FIFO.
// Optional output saturation is enabled by defining FIR_OUT_SAT_EN.
module fir_output_decimator #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15,
  parameter int DECIM     = 4,
  parameter int WARMUP    = 8,
  parameter int DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IN_WIDTH-1:0]          in_sample,
  input  logic                         in_valid,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         overflow,
  output logic                         sat_hit
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int WW = WARMUP > 0 ? $clog2(WARMUP + 1) : 1;
  localparam int DW = DECIM > 1 ? $clog2(DECIM) : 1;
  localparam logic [IN_WIDTH:0] RND = ({{IN_WIDTH{1'b0}}, 1'b1} << SHIFT) >> 1;
  typedef enum logic {WARM, RUN} state_t;
  localparam state_t INIT = WARMUP == 0 ? RUN : WARM;
  state_t state_q, state_d;
  logic [WW-1:0] warm_q, warm_d;
  logic [DW-1:0] dec_q, dec_d;
  logic keep;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      warm_q  <= '0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      dec_q   <= dec_d;
    end
  end
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    dec_d   = dec_q;
    if (in_valid && state_q == WARM) begin
      warm_d  = warm_q + 1'b1;
      state_d = warm_d == WW'(WARMUP) ? RUN : WARM;
    end
    if (in_valid && state_q == RUN) dec_d = dec_q == DW'(DECIM - 1) ? '0 : dec_q + 1'b1;
  end
  always_comb begin
    keep = in_valid && state_q == RUN && dec_q == '0;
  end
  // One guard bit keeps the rounding addend from overflowing the input range.
  logic signed [IN_WIDTH:0] v;
  logic [OUT_WIDTH-1:0] scaled;
  logic clamp;
  assign v = {in_sample[IN_WIDTH-1], in_sample} + RND;
`ifdef FIR_OUT_SAT_EN
  localparam logic signed [IN_WIDTH:0] MAXV = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] MINV = ~MAXV;
  logic signed [IN_WIDTH:0] r;
  assign r      = v >>> SHIFT;
  assign clamp  = r > MAXV || r < MINV;
  assign scaled = r > MAXV ? MAXV[OUT_WIDTH-1:0] : r < MINV ? MINV[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];
`else
  assign clamp  = 1'b0;
  assign scaled = OUT_WIDTH'(v >>> SHIFT);
`endif
  logic s_valid_q;
  logic [OUT_WIDTH-1:0] s_data_q;
  logic [OUT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q, level_d;
  logic valid_q, ovf_q, sat_q, pop, push;
  assign pop     = valid_q && out_ready;
  assign push    = s_valid_q && (level_q != LW'(DEPTH) || pop);
  assign level_d = level_q + LW'(push) - LW'(pop);
  always_ff @(posedge clk) begin
    if (reset) begin
      s_valid_q <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      level_q   <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      s_valid_q <= keep;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      level_q   <= level_d;
      valid_q   <= level_d != '0;
      ovf_q     <= ovf_q | (s_valid_q & ~push);
      sat_q     <= sat_q | (keep & clamp);
    end
  end
  always_ff @(posedge clk) begin
    if (keep) s_data_q <= scaled;
    if (push) mem[wr_q] <= s_data_q;
  end
  assign out_data   = valid_q ? mem[rd_q] : '0;
  assign out_valid  = valid_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign sat_hit    = sat_q;
endmodule

// File: tb/tb_fir_output_decimator.sv
// tb_fir_output_decimator: two configurations checked against a sample-counting queue model plus directed sequences.
module tb_fir_output_decimator;
  localparam int MW [2] = '{8, 0};
  localparam int MD [2] = '{4, 1};
  localparam int MS [2] = '{0, 2};
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [31:0] in_sample = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [15:0] od [2];
  logic ov [2], oo [2], os [2];
  logic [3:0] lv [2];
  int n_chk = 0, n_err = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;

  fir_output_decimator #(.IN_WIDTH(32), .OUT_WIDTH(16), .SHIFT(0), .DECIM(4), .WARMUP(8), .DEPTH(8)) u_a (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .fifo_level(lv[0]), .overflow(oo[0]), .sat_hit(os[0]));
  fir_output_decimator #(.IN_WIDTH(32), .OUT_WIDTH(16), .SHIFT(2), .DECIM(1), .WARMUP(0), .DEPTH(8)) u_b (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .fifo_level(lv[1]), .overflow(oo[1]), .sat_hit(os[1]));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [15:0] scale(input logic signed [31:0] x, input int sh, output bit f);
    longint v = longint'(x) + (sh > 0 ? (64'sd1 <<< (sh - 1)) : 64'sd0);
    v = v >>> sh;
    f = 0;
`ifdef FIR_OUT_SAT_EN
    if (v > 32767) begin f = 1; v = 32767; end
    else if (v < -32768) begin f = 1; v = -32768; end
`endif
    return 16'(v);
  endfunction

  // Reference: counts samples since reset, keeps every DECIM-th after WARMUP, one-slot scale delay, bounded queue.
  int m_seen [2], m_run [2], m_cnt [2], m_head [2];
  bit m_sv [2], m_ovf [2], m_sat [2];
  logic signed [15:0] m_sd [2];
  logic signed [15:0] m_buf [2][8];
  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_seen[k] = 0; m_run[k] = 0; m_cnt[k] = 0; m_head[k] = 0;
        m_sv[k] = 0; m_ovf[k] = 0; m_sat[k] = 0;
      end else begin
        bit f;
        if (m_cnt[k] > 0 && out_ready) begin m_head[k] = (m_head[k] + 1) % 8; m_cnt[k]--; end
        if (m_sv[k]) begin
          if (m_cnt[k] < 8) begin m_buf[k][(m_head[k] + m_cnt[k]) % 8] = m_sd[k]; m_cnt[k]++; end
          else m_ovf[k] = 1;
        end
        m_sv[k] = 0;
        if (in_valid) begin
          if (m_seen[k] < MW[k]) m_seen[k]++;
          else begin
            if (m_run[k] % MD[k] == 0) begin
              m_sv[k] = 1;
              m_sd[k] = scale(in_sample, MS[k], f);
              m_sat[k] = m_sat[k] | f;
            end
            m_run[k]++;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en)
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("k%0d_valid", k), int'(ov[k]), int'(m_cnt[k] > 0));
        chk($sformatf("k%0d_level", k), int'(lv[k]), m_cnt[k]);
        if (m_cnt[k] > 0) chk($sformatf("k%0d_data", k), int'(od[k]), int'(m_buf[k][m_head[k]]));
        chk($sformatf("k%0d_ovf", k), int'(oo[k]), int'(m_ovf[k]));
        chk($sformatf("k%0d_sat", k), int'(os[k]), int'(m_sat[k]));
      end
  end

  task automatic step(input logic v, input logic signed [31:0] x, input logic rdy);
    @(negedge clk);
    in_valid = v;
    in_sample = x;
    out_ready = rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic signed [31:0] x;
    logic signed [15:0] y;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int first;
    int got [$];
    tbl[0] = '{5, 1};
    tbl[1] = '{6, 2};
    tbl[2] = '{-6, -1};
    tbl[3] = '{-5, -1};
    tbl[4] = '{2, 1};
    tbl[5] = '{-2, 0};
`ifdef FIR_OUT_SAT_EN
    tbl[6] = '{160000, 32767};
    tbl[7] = '{-160000, -32768};
`else
    tbl[6] = '{160000, -25536};
    tbl[7] = '{-160000, 25536};
`endif
    do_reset();
    chk_en = 1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", int'(ov[k]), 0);
      chk("rst_level", int'(lv[k]), 0);
      chk("rst_data", int'(od[k]), 0);
      chk("rst_ovf", int'(oo[k]), 0);
      chk("rst_sat", int'(os[k]), 0);
    end
    // Rounding/wrap table through the SHIFT=2, DECIM=1, WARMUP=0 instance.
    for (int i = 0; i < 8; i++) step(1'b1, tbl[i].x, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("tbl_level", int'(lv[1]), 8);
    chk("tbl_ovf", int'(oo[1]), 0);
`ifdef FIR_OUT_SAT_EN
    chk("tbl_sat", int'(os[1]), 1);
`else
    chk("tbl_sat", int'(os[1]), 0);
`endif
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 0, 1'b1);
      chk($sformatf("tbl_out%0d", i), int'(od[1]), int'(tbl[i].y));
    end
    // Warm-up and decimation on the WARMUP=8, DECIM=4, SHIFT=0 instance.
    do_reset();
    first = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ov[0]) begin
        if (first < 0) first = i;
        got.push_back(int'(od[0]));
      end
      in_valid = 1'b1;
      in_sample = i;
      out_ready = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ov[0]) got.push_back(int'(od[0]));
      in_valid = 1'b0;
    end
    chk("warm_first", first, 10);
    chk("warm_count", got.size(), 14);
    foreach (got[j]) chk($sformatf("warm_out%0d", j), got[j], 8 + 4 * j);
    // Full FIFO with refused writes, then drain in order.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 100 + 4 * i, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("full_level", int'(lv[1]), 8);
    chk("full_ovf", int'(oo[1]), 1);
    for (int j = 0; j < 8; j++) begin
      step(1'b0, 0, 1'b1);
      chk($sformatf("drain%0d", j), int'(od[1]), 25 + j);
    end
    step(1'b0, 0, 1'b0);
    chk("drain_empty", int'(ov[1]), 0);
    // Push and pop on the same edge while full.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 100 + 4 * i, 1'b0);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    chk("pp_level", int'(lv[1]), 8);
    chk("pp_ovf", int'(oo[1]), 0);
    for (int j = 0; j < 8; j++) begin
      step(1'b0, 0, 1'b1);
      chk($sformatf("pp_out%0d", j), int'(od[1]), 26 + j);
    end
    // Reset mid-stream with five entries queued in the decimating instance.
    do_reset();
    for (int i = 0; i < 28; i++) step(1'b1, i, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("mid_level", int'(lv[0]), 5);
    do_reset();
    for (int k = 0; k < 2; k++) begin
      chk("mid_rst_level", int'(lv[k]), 0);
      chk("mid_rst_valid", int'(ov[k]), 0);
      chk("mid_rst_ovf", int'(oo[k]), 0);
    end
    for (int i = 0; i < 8; i++) step(1'b1, 500 + i, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    chk("rewarm_quiet", int'(ov[0]), 0);
    step(1'b1, 777, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    chk("rewarm_valid", int'(ov[0]), 1);
    chk("rewarm_data", int'(od[0]), 777);
    // Randomised traffic with occasional resets and back-pressure phases.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = $urandom_range(299) == 0;
      in_valid = $urandom_range(3) != 0;
      out_ready = $urandom_range(99) < (((c / 400) % 2) != 0 ? 30 : 90);
      case ($urandom_range(2))
        0: in_sample = $urandom;
        1: in_sample = int'($urandom_range(2000)) - 1000;
        default: in_sample = int'($urandom_range(400000)) - 200000;
      endcase
    end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
